ahb_uart_master: RTL
====================

AHB_UART_MASTER -- requirements
Module: ahb_uart_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum consecutive HREADY-low data-phase cycles before the transfer is abandoned.
REQ-002 HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 HRESET  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  byte address of the UART register.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  one-cycle pulse: transfer complete.
REQ-010 rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-011 rsp_err  output  1  error or timeout, valid with rsp_valid.
REQ-012 HADDR / HTRANS / HWRITE / HSIZES / HBURST / HSELABPif  output  32/2/1/2/3/1  AHB address-phase signals toward the bridge.
REQ-013 HWDATA  output  32  AHB write data, data phase.
REQ-014 HREADYin / HRESP / HRDATA  input  1/2/32  bridge completion, response and read data.
REQ-015 err_count  output  8  saturating count of errored or timed-out transfers.

Function
REQ-016 States IDLE, ADDR, DATA, RESP. The FSM never pipelines: one transfer is outstanding at a time.
REQ-017 cmd_ready = 1 only in IDLE. On a handshake, latch cmd_write, cmd_addr and cmd_wdata, then go to ADDR.
REQ-018 ADDR: drive HTRANS = NONSEQ, HSELABPif = 1, HBURST = SINGLE, HSIZES = WORD, HADDR = {addr[31:2], 2'b00}, HWRITE = latched write.
- Hold these until HREADYin = 1 at a rising edge, then go to DATA.
REQ-019 In DATA and RESP, drive HTRANS = IDLE and HSELABPif = 0.
- HWDATA = latched wdata throughout DATA; HWDATA = 0 otherwise.
REQ-020 DATA completes at the first edge with HREADYin = 1, then goes to RESP.
- rsp_rdata = HRDATA sampled at that edge for reads, 0 for writes.
REQ-021 Any HRESP ≠ OKAY (2'b00) sampled in DATA sets a sticky error.
- Completion still waits for HREADYin = 1.
- At completion: rsp_err = 1, rsp_rdata = 0.
REQ-022 A wait counter increments on each DATA cycle with HREADYin = 0 and clears on entering DATA.
- When it reaches TIMEOUT_CYCLES: go to RESP with rsp_err = 1, rsp_rdata = 0.
REQ-023 RESP lasts exactly one cycle. It asserts rsp_valid, increments err_count (saturating at 255) if rsp_err, then returns to IDLE.
REQ-024 Zero-wait latency: handshake edge T; ADDR during T+1; DATA during T+2; rsp_valid during T+3; cmd_ready high again in T+4.
REQ-025 cmd_valid in any non-IDLE state is ignored and not queued. Changing cmd_* after the handshake does not affect the transfer in flight.

Reset
REQ-026 HRESET = 1 at an edge, in any state including mid-transfer, forces IDLE with no rsp_valid pulse.
- Outputs: HTRANS = IDLE, HSELABPif = 0, HADDR = 0, HWDATA = 0, HWRITE = 0, HSIZES = WORD, HBURST = SINGLE.
- Outputs: cmd_ready = 0 during reset, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_count = 0.
- The wait counter also clears to 0.

Structure
REQ-027 Package ahb_uart_pkg holds: HTRANS encodings (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11); HRESP OKAY 00 / ERROR 01; HBURST SINGLE 000; HSIZES WORD 10; the FSM state enum.
REQ-028 The wait counter with its terminal-count compare is sub-module ahb_wait_timer.
- Width = $clog2(TIMEOUT_CYCLES+1).
- Inputs: clear, enable. Output: expired.

Verification
REQ-029 Write to 0x0000_0004 with data 0x41, zero waits.
- Required: NONSEQ with HADDR = 0x4 in T+1; HWDATA = 0x41 in T+2; rsp_valid in T+3 with rsp_err = 0.
REQ-030 Read from 0x0000_0008 with HREADYin low for 3 DATA cycles, then HRDATA = 0x5A.
- Required: rsp_rdata = 0x5A, rsp_err = 0, rsp_valid exactly 3 cycles later than the zero-wait case.
REQ-031 Bridge returns HRESP = 01 in the DATA phase.
- Required: rsp_err = 1, rsp_rdata = 0, err_count 0 → 1.
REQ-032 HREADYin held 0 with TIMEOUT_CYCLES = 4.
- Required: rsp_err = 1 five cycles after DATA entry; the next command is accepted.
REQ-033 Assert HRESET during a DATA wait state.
- Required: no rsp_valid, HTRANS = IDLE next cycle, cmd_ready = 1 the cycle after reset deasserts.
REQ-034 Force 256 errored transfers.
- Required: err_count saturates at 255.

Source files
------------

// File: rtl/ahb_uart_pkg.sv
// Shared AHB encodings and FSM state type for the UART-bridge master.
package ahb_uart_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HSIZE_WORD    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/ahb_uart_master_if.sv
// Command/response handshake plus AHB bus toward the UART bridge.
// master = the ahb_uart_master view, slave = the requester/bridge side.
interface ahb_uart_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [1:0]  HSIZES;
    logic [2:0]  HBURST;
    logic        HSELABPif;
    logic [31:0] HWDATA;
    logic        HREADYin;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADYin, HRESP, HRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               HADDR, HTRANS, HWRITE, HSIZES, HBURST, HSELABPif, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADYin, HRESP, HRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               HADDR, HTRANS, HWRITE, HSIZES, HBURST, HSELABPif, HWDATA
    );
endinterface

// File: rtl/ahb_wait_timer.sv
// Data-phase wait counter; expired is combinational on the held count.
// Counts enabled cycles, holds at TIMEOUT_CYCLES, clears on clear or rst.
module ahb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] TERMINAL = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TERMINAL);

endmodule

// File: rtl/ahb_uart_master.sv
// Single-outstanding AHB master for the UART bridge: IDLE->ADDR->DATA->RESP.
// Zero-wait command-to-response is 3 cycles; cmd_ready is only high in IDLE.
module ahb_uart_master
    import ahb_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_uart_master_if.master bus,
    output logic [7:0]        err_count
);
    state_e      state;
    logic        write_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_sticky;
    logic        err_q;
    logic        hresp_bad;
    logic        expired;
    logic        in_addr;
    logic        in_data;

    assign hresp_bad = (bus.HRESP != HRESP_OKAY);
    assign in_addr   = (state == ST_ADDR);
    assign in_data   = (state == ST_DATA);

    ahb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
        .clk     (HCLK),
        .rst     (HRESET),
        .clear   (!in_data),
        .enable  (in_data && !bus.HREADYin),
        .expired (expired)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_sticky <= 1'b0;
            err_q      <= 1'b0;
            err_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        write_q    <= bus.cmd_write;
                        addr_q     <= bus.cmd_addr[31:2];
                        wdata_q    <= bus.cmd_wdata;
                        err_sticky <= 1'b0;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADYin) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (hresp_bad) begin
                        err_sticky <= 1'b1;
                    end
                    // A ready completion wins over a timeout landing on the same edge.
                    if (bus.HREADYin) begin
                        state   <= ST_RESP;
                        err_q   <= err_sticky || hresp_bad;
                        rdata_q <= (err_sticky || hresp_bad || write_q) ? 32'h0 : bus.HRDATA;
                    end else if (expired) begin
                        state   <= ST_RESP;
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    if (err_q && err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == ST_IDLE) && !HRESET;
    assign bus.HTRANS    = in_addr ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HSELABPif = in_addr;
    assign bus.HADDR     = in_addr ? {addr_q, 2'b00} : 32'h0;
    assign bus.HWRITE    = in_addr && write_q;
    assign bus.HSIZES    = HSIZE_WORD;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HWDATA    = in_data ? wdata_q : 32'h0;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = (state == ST_RESP) ? rdata_q : 32'h0;
    assign bus.rsp_err   = (state == ST_RESP) && err_q;

endmodule
